// File: rtl/iter_alu.sv
// Purpose : multi-cycle ALU: add/sub/logic/shift/compare in one cycle, iterative unsigned multiply (and divide).
// Latency : single-cycle ops raise done 1 edge after accept; MULU/DIVU/REMU raise done WIDTH+1 edges after accept.
// Backpr. : start is accepted in IDLE or DONE only; while busy=1 start is ignored (no queueing).
//
// Ports:
//   CLK, Reset         rising-edge clock, asynchronous active-high reset
//   start, ALUOp, A, B request and operands, captured on the accepting edge
//   busy, done         busy high during iteration; done is a one-cycle pulse
//   result, result_hi  primary result; product high half / remainder / quotient
//   zero, neg, carry, ovf  flags, updated together with result on the done edge
//
// Optional feature: define ITER_ALU_DIV_EN to build the restoring divider for
// DIVU (1110) and REMU (1111). Without it those codes return 0 in one cycle.
module iter_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic [3:0]       ALUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_RSUB = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_ANDN = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_XNOR = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b1011;
  localparam logic [3:0] OP_SLTU = 4'b1100;
  localparam logic [3:0] OP_MULU = 4'b1101;
`ifdef ITER_ALU_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'b1110;
  localparam logic [3:0] OP_REMU = 4'b1111;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  // Multiplicand for MULU, divisor for DIVU/REMU.
  logic [WIDTH-1:0] opnd_q, opnd_d;
  // Shared {hi,lo} shift pair: partial product / (remainder, quotient).
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic             is_iter_op;
  logic             accept;

  // ---------------- single-cycle datapath (operates on live inputs) --------
  logic [WIDTH-1:0] add_x, add_y;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic             add_ovf;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry, sc_ovf;

  always_comb begin
    // Subtraction is x + ~y + 1, so SUB and RSUB share the adder with ADD.
    add_x   = A;
    add_y   = B;
    add_cin = 1'b0;
    case (ALUOp)
      OP_SUB:  begin add_y = ~B; add_cin = 1'b1; end
      OP_RSUB: begin add_x = B; add_y = ~A; add_cin = 1'b1; end
      default: ;
    endcase
    add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    add_ovf = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (add_sum[WIDTH-1] != add_x[WIDTH-1]);
    shamt   = A[SHW-1:0];

    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    case (ALUOp)
      OP_ADD:  begin sc_res = add_sum[WIDTH-1:0]; sc_carry = add_sum[WIDTH]; sc_ovf = add_ovf; end
      // No carry-out of x + ~y + 1 means the subtrahend was larger: borrow.
      OP_SUB,
      OP_RSUB: begin sc_res = add_sum[WIDTH-1:0]; sc_carry = ~add_sum[WIDTH]; sc_ovf = add_ovf; end
      OP_OR:   sc_res = A | B;
      OP_AND:  sc_res = A & B;
      OP_ANDN: sc_res = ~A & B;
      OP_XOR:  sc_res = A ^ B;
      OP_XNOR: sc_res = ~A ^ B;
      OP_SLL:  sc_res = B << shamt;
      OP_SRL:  sc_res = B >> shamt;
      OP_SRA:  sc_res = $unsigned($signed(B) >>> shamt);
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
      default: sc_res = '0;
    endcase
  end

  always_comb begin
    is_iter_op = (ALUOp == OP_MULU);
`ifdef ITER_ALU_DIV_EN
    is_iter_op = is_iter_op || (ALUOp == OP_DIVU) || (ALUOp == OP_REMU);
`endif
  end

  // ---------------- iterative datapath (operates on captured state) --------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;
  logic [WIDTH-1:0] step_hi, step_lo;
`ifdef ITER_ALU_DIV_EN
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] div_hi_nx, div_lo_nx;
`endif

  always_comb begin
    // Shift-add: add multiplicand into the high half when the multiplier LSB
    // is set, then shift the whole {carry,hi,lo} pair right by one.
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_hi_nx = mul_sum[WIDTH:1];
    mul_lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};
    step_hi   = mul_hi_nx;
    step_lo   = mul_lo_nx;
`ifdef ITER_ALU_DIV_EN
    // Restoring division: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. A zero divisor always "fits", which
    // yields an all-ones quotient and leaves the dividend as the remainder.
    rem_sh = {hi_q, lo_q[WIDTH-1]};
    if (rem_sh >= {1'b0, opnd_q}) begin
      div_hi_nx = rem_sh[WIDTH-1:0] - opnd_q;
      div_lo_nx = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      div_hi_nx = rem_sh[WIDTH-1:0];
      div_lo_nx = {lo_q[WIDTH-2:0], 1'b0};
    end
    if (op_q != OP_MULU) begin
      step_hi = div_hi_nx;
      step_lo = div_lo_nx;
    end
`endif
  end

  // ---------------- control ------------------------------------------------
  assign accept = start && (state_q != S_ITER);

  logic [WIDTH-1:0] fin_res, fin_hi;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    opnd_d      = opnd_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    fin_res     = step_lo;
    fin_hi      = step_hi;

    case (state_q)
      S_ITER: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + SHW'(1);
        if (&cnt_q) begin
          state_d = S_DONE;
          case (op_q)
`ifdef ITER_ALU_DIV_EN
            OP_DIVU: begin fin_res = step_lo; fin_hi = step_hi; zero_d = ~|step_lo; end
            OP_REMU: begin fin_res = step_hi; fin_hi = step_lo; zero_d = ~|step_hi; end
`endif
            default: begin fin_res = step_lo; fin_hi = step_hi; zero_d = ~|{step_hi, step_lo}; end
          endcase
          result_d    = fin_res;
          result_hi_d = fin_hi;
          neg_d       = fin_res[WIDTH-1];
          carry_d     = 1'b0;
          ovf_d       = 1'b0;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request.
        state_d = S_IDLE;
        if (accept) begin
          op_d = ALUOp;
          if (is_iter_op) begin
            state_d = S_ITER;
            cnt_d   = '0;
            hi_d    = '0;
            lo_d    = (ALUOp == OP_MULU) ? B : A;
            opnd_d  = (ALUOp == OP_MULU) ? A : B;
          end else begin
            state_d     = S_DONE;
            result_d    = sc_res;
            result_hi_d = '0;
            zero_d      = ~|sc_res;
            neg_d       = sc_res[WIDTH-1];
            carry_d     = sc_carry;
            ovf_d       = sc_ovf;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      opnd_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b1;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      opnd_q      <= opnd_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
    end
  end

  assign busy      = (state_q == S_ITER);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Parametrised, multi-cycle successor to the single-cycle CPU ALU.
- Keeps the eight original operations and adds shifts, set-less-than, a full NZCV flag set, and an iterative unsigned multiplier.
- Uses a start/done handshake so the multi-cycle control unit can stall while the ALU is busy.
- Sits between the register-file read stage and the write-back mux.

Parameters:
- WIDTH, 32, operand and result width in bits (>=4, power of two).
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- CLK  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- ALUOp  input  4  operation code, captured with start.
- A  input  WIDTH  operand 1, captured with start.
- B  input  WIDTH  operand 2, captured with start.
- busy  output  1  high while an iterative op runs.
- done  output  1  one-cycle pulse; results valid from this cycle.
- result  output  WIDTH  primary result (product low half for MULU).
- result_hi  output  WIDTH  product high half for MULU / remainder for REMU, else 0.
- zero  output  1  1 when result (and result_hi for MULU) is all zeros.
- neg  output  1  result[WIDTH-1].
- carry  output  1  ADD: carry-out; SUB/RSUB: borrow (minuend < subtrahend, unsigned); else 0.
- ovf  output  1  signed overflow for ADD/SUB/RSUB, else 0.

Behaviour:
- Reset (async, any state):
  - state=IDLE; busy=0, done=0, result=0, result_hi=0.
  - zero=1; neg, carry, ovf all 0.
  - Any in-flight op is discarded; no done is issued.
- ALUOp encoding:
  - 0000 ADD A+B; 0001 SUB A-B; 0010 RSUB B-A; 0011 OR; 0100 AND; 0101 ANDN ~A&B; 0110 XOR; 0111 XNOR ~A^B.
  - 1000 SLL B<<A[SHW-1:0]; 1001 SRL logical; 1010 SRA arithmetic.
  - 1011 SLT signed A<B -> 1/0; 1100 SLTU unsigned A<B -> 1/0.
  - 1101 MULU; 1110 DIVU; 1111 REMU (the last two under the optional feature).
- Register capture: A, B and ALUOp are registered at accept. Changes on the inputs after accept have no effect.
- States:
  - IDLE -> DONE when start is accepted with a single-cycle op (ALUOp <= 1100).
  - IDLE -> ITER when start is accepted with an iterative op; ITER lasts exactly WIDTH cycles.
  - ITER -> DONE after the last iteration.
  - DONE -> IDLE, or directly into the next op if start=1 in DONE; DONE accepts start like IDLE.
- Latency and throughput:
  - Single-cycle op: done on the 1st edge after accept. Back-to-back issue gives one result every cycle.
  - MULU: radix-2 shift-add, one bit per cycle, done WIDTH+1 edges after accept.
- Output hold: result, result_hi and flags update only on the edge that raises done, and hold until the next done.
- busy=1 only in ITER. start while busy=1 is ignored, with no queueing.
- Arithmetic:
  - Add/sub use a WIDTH+1-bit sum.
  - ovf = operand signs equal (after subtrahend inversion) and result sign differs.
  - Shift amounts >= WIDTH cannot occur, because only the low SHW bits are used.
  - MULU: {result_hi,result} = A*B, 2*WIDTH bits, unsigned.
- Unused codes (1110/1111 without the feature): single-cycle; result=0, result_hi=0, zero=1.

Optional Feature:
- Macro: ITER_ALU_DIV_EN.
- Defined:
  - 1110 DIVU and 1111 REMU use a restoring divider, one quotient bit per cycle.
  - Latency equals MULU (WIDTH+1).
  - DIVU: result=quotient, result_hi=remainder. REMU: result=remainder, result_hi=quotient.
  - Divide by zero: quotient all ones, remainder=A, same latency.
- Undefined: divider logic is absent; 1110/1111 behave as unused codes.

Test Plan:
- Reset asserted mid-MULU (cycle 10 of ITER) -> next edge busy=0, result=0, zero=1; no done pulse follows.
- start, ADD, A=0x7FFFFFFF, B=1 -> 1 edge later: done=1, result=0x80000000, neg=1, ovf=1, carry=0, zero=0.
- SUB, A=3, B=5 -> result=0xFFFFFFFE, carry=1, ovf=0. Issued back-to-back with RSUB (same A, B) -> next cycle result=2, carry=0.
- MULU, A=0xFFFFFFFF, B=0xFFFFFFFF -> busy high 32 cycles, done at edge 33: result=0x00000001, result_hi=0xFFFFFFFE. A second start issued while busy is ignored.
- SRA, A=4, B=0x80000000 -> result=0xF8000000. SLT, A=0xFFFFFFFF, B=1 -> 1. SLTU, same operands -> 0, zero=1.
- With ITER_ALU_DIV_EN: DIVU 100/7 -> result=14, result_hi=2 at edge 33; DIVU 5/0 -> result=0xFFFFFFFF, result_hi=5. Without the macro: DIVU -> done after 1 edge, result=0.
